// File: rtl/calc_op_sequencer.sv
// -----------------------------------------------------------------------------
// calc_op_sequencer
//
// Control and sequencing block for the calculator datapath. It takes one
// operation request at a time (opcode plus two WIDTH-bit operands), runs it
// through the bitwise units, the adder/subtractor or an iterative shift-add
// multiplier, and returns a registered result with flags.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds valid and its payload
// until that edge; ready may be computed combinationally. Here in_ready
// depends only on state and rst_n, never on in_valid, and out_valid depends
// only on state, never on out_ready.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   request present
//   in_ready   block can accept a request (IDLE and not in reset)
//   opcode     000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 MUL,
//              110 NOT a, 111 illegal
//   a, b       operands
//   out_valid  result valid (DONE state)
//   out_ready  consumer accepts result
//   result     2*WIDTH-bit result, held after the output handshake
//   carry      ADD carry-out / SUB borrow
//   zero       result == 0 over all 2*WIDTH bits
//   err        the last accepted opcode was illegal
// -----------------------------------------------------------------------------
module calc_op_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         opcode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               zero,
  output logic               err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] partial;
  logic [CW-1:0]      cnt;
  logic               accept;
  logic               mul_last;

  logic [2*WIDTH-1:0] alu_res;
  logic               alu_carry;
  logic               alu_err;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;

  assign accept   = in_valid && in_ready;
  assign mul_last = (cnt == CW'(WIDTH - 1));

  // One shift-add step: add a_reg shifted to the current bit position when
  // that bit of b_reg is set.
  assign partial = {{WIDTH{1'b0}}, a_reg} << cnt;
  assign acc_nxt = b_reg[cnt] ? (acc + partial) : acc;

  // Single-cycle operations, evaluated on the live inputs so the result can
  // be registered on the accepting edge.
  always_comb begin
    sum_ext   = {1'b0, a} + {1'b0, b};
    // Extending by one zero bit makes bit WIDTH of the difference the borrow.
    diff_ext  = {1'b0, a} - {1'b0, b};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    case (opcode)
      OP_AND: alu_res[WIDTH-1:0] = a & b;
      OP_OR:  alu_res[WIDTH-1:0] = a | b;
      OP_XOR: alu_res[WIDTH-1:0] = a ^ b;
      OP_ADD: begin
        alu_res[WIDTH-1:0] = sum_ext[WIDTH-1:0];
        alu_carry          = sum_ext[WIDTH];
      end
      OP_SUB: begin
        alu_res[WIDTH-1:0] = diff_ext[WIDTH-1:0];
        alu_carry          = diff_ext[WIDTH];
      end
      OP_NOT: alu_res[WIDTH-1:0] = ~a;
      OP_ILL: alu_err = 1'b1;
      default: alu_res = '0;  // OP_MUL: result comes from the iterations
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (opcode == OP_MUL) ? ST_MUL : ST_DONE;
        end
      end
      ST_MUL: begin
        if (mul_last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    in_ready  = (state == ST_IDLE) && rst_n;
    out_valid = (state == ST_DONE);
  end

  // Datapath registers. A reset during MUL simply drops the partial product.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      err    <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      carry <= alu_carry;
      err   <= alu_err;
      if (opcode == OP_MUL) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        result <= alu_res;
        zero   <= (alu_res == '0);
      end
    end else if (state == ST_MUL) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (mul_last) begin
        result <= acc_nxt;
        zero   <= (acc_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_op_sequencer
//
// Self-checking bench for calc_op_sequencer. Expected results come from an
// integer-arithmetic reference model and are carried through an expected
// queue. Inputs change 1 ns after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_calc_op_sequencer;

  localparam int W = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [2:0]     opcode = 3'd0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           in_ready;
  logic           out_valid;
  logic [2*W-1:0] result;
  logic           carry;
  logic           zero;
  logic           err;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  calc_op_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .err       (err)
  );

  // ---------------------------------------------------------------------------
  // Reference model: plain integer arithmetic on the operand values.
  // ---------------------------------------------------------------------------
  function automatic void ref_model(input logic [2:0] op, input logic [W-1:0] x,
                                    input logic [W-1:0] y, output logic [2*W-1:0] r,
                                    output logic c, output logic e);
    int xi;
    int yi;
    int m;
    xi = int'(x);
    yi = int'(y);
    m  = 1 << W;
    r  = '0;
    c  = 1'b0;
    e  = 1'b0;
    case (op)
      3'd0: r = (2*W)'(x & y);
      3'd1: r = (2*W)'(x | y);
      3'd2: r = (2*W)'(x ^ y);
      3'd3: begin
        r = (2*W)'((xi + yi) % m);
        c = ((xi + yi) >= m);
      end
      3'd4: begin
        r = (2*W)'((xi - yi + m) % m);
        c = (xi < yi);
      end
      3'd5: r = (2*W)'(xi * yi);
      3'd6: r = (2*W)'(m - 1 - xi);
      default: e = 1'b1;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: issue one request, follow it to the output handshake, checking
  // latency, busy behaviour, result/flags and stability under backpressure.
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int stall, input string tag);
    logic [2*W-1:0] er;
    logic [2*W-1:0] exp_r;
    logic           ec;
    logic           ee;
    int             lat;
    int             exp_lat;
    bit             busy_bad;
    ref_model(op, x, y, er, ec, ee);
    exp_q.push_back(er);
    exp_lat  = (op == 3'd5) ? W + 1 : 1;
    busy_bad = 1'b0;

    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_ready: got %b want 1", tag, in_ready);
    end

    opcode = op; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    lat = 1;
    // Keep requesting with junk operands: it must be ignored while busy.
    while (out_valid !== 1'b1 && lat <= 2*W + 4) begin
      if (in_ready !== 1'b0) busy_bad = 1'b1;
      opcode    = 3'($urandom);
      a         = W'($urandom);
      b         = W'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end

    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL %s busy_ready: in_ready got 1 want 0 while busy", tag);
    end

    exp_r = exp_q.pop_front();
    checks++;
    if (result !== exp_r) begin
      errors++;
      $display("FAIL %s result: got %h want %h", tag, result, exp_r);
    end
    checks++;
    if ({carry, zero, err} !== {ec, (exp_r == '0), ee}) begin
      errors++;
      $display("FAIL %s flags(c,z,e): got %b%b%b want %b%b%b", tag, carry, zero, err,
               ec, (exp_r == '0), ee);
    end

    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      opcode   = 3'($urandom);
      a        = W'($urandom);
      b        = W'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp_r ||
          {carry, zero, err} !== {ec, (exp_r == '0), ee}) begin
        errors++;
        $display("FAIL %s hold[%0d]: got v=%b r=%b res=%h want v=1 r=0 res=%h",
                 tag, i, out_valid, in_ready, result, exp_r);
      end
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== exp_r) begin
      errors++;
      $display("FAIL %s handshake: got v=%b r=%b res=%h want v=0 r=1 res=%h",
               tag, out_valid, in_ready, result, exp_r);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0", in_ready);
    end
    checks++;
    if ({out_valid, result, carry, zero, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b res=%h c=%b z=%b e=%b want all 0",
               out_valid, result, carry, zero, err);
    end
    rst_n = 1'b1; out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bitwise();
    run_op(3'd0, 8'hF0, 8'h3C, 0, "and");
    run_op(3'd1, 8'hA0, 8'h05, 0, "or");
    run_op(3'd6, 8'h0F, 8'h77, 0, "not");
    run_op(3'd6, 8'hFF, 8'h00, 0, "not_zero");
  endtask

  task automatic test_add_sub();
    run_op(3'd3, 8'hFF, 8'h01, 0, "add_wrap");
    run_op(3'd3, 8'h12, 8'h34, 0, "add");
    run_op(3'd4, 8'h05, 8'h07, 0, "sub_borrow");
    run_op(3'd4, 8'h07, 8'h05, 0, "sub");
    run_op(3'd4, 8'h33, 8'h33, 0, "sub_zero");
  endtask

  task automatic test_mul();
    run_op(3'd5, 8'hFF, 8'hFF, 0, "mul_max");
    run_op(3'd5, 8'h00, 8'h9A, 0, "mul_zero_a");
    run_op(3'd5, 8'h9A, 8'h00, 1, "mul_zero_b");
    run_op(3'd5, 8'h0D, 8'h0B, 0, "mul");
  endtask

  task automatic test_backpressure();
    run_op(3'd2, 8'hAA, 8'h55, 5, "xor_bp");
    run_op(3'd5, 8'h81, 8'h7E, 4, "mul_bp");
  endtask

  task automatic test_reset_mid_mul();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmm_idle_ready: got %b want 1", in_ready);
    end
    opcode = 3'd5; a = 8'hC3; b = 8'hFF; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rmm_ready_in_reset: got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, result, carry, zero, err} !== '0) begin
      errors++;
      $display("FAIL rmm_outputs: got v=%b res=%h c=%b z=%b e=%b want all 0",
               out_valid, result, carry, zero, err);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmm_ready_after: got %b want 1", in_ready);
    end
    repeat (W + 2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL rmm_discarded: got v=%b res=%h want v=0 res=0000", out_valid, result);
    end
    run_op(3'd3, 8'h21, 8'h42, 0, "add_after_reset");
  endtask

  task automatic test_illegal();
    run_op(3'd7, 8'h5A, 8'hA5, 0, "illegal");
    run_op(3'd1, 8'h01, 8'h02, 0, "or_after_illegal");
    run_op(3'd7, 8'h00, 8'h00, 2, "illegal_bp");
    run_op(3'd5, 8'h03, 8'h04, 0, "mul_after_illegal");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 0, "b2b");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
             int'($urandom_range(0, 3)), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_bitwise();
    test_add_sub();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
